spi_share_arbiter: RTL and testbench

SPI_SHARE_ARBITER -- requirements
Module: spi_share_arbiter

---
 rtl/spi_share_arbiter.sv | 175 +++++++++++++++++
 tb/tb_spi_share_arbiter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/spi_share_arbiter.sv
// spi_share_arbiter
//   Shares one SPI pad set between two requesters. The owner's ss/sclk/mosi
//   pass straight through to the pads, and pad MISO returns only to the owner.
//   A new owner is granted only after a quiet gap with ss high and sclk low.
//   Ownership ends only at a transfer boundary: req dropped while ss is high.
//
// Optional feature: define SPI_ARB_TIMEOUT_EN to bound how long one owner may
//   hold the bus. When the bound is reached the owner is revoked, timeout_irq
//   pulses for one cycle, and the revoked requester must drop req before it
//   can be granted again.
//
// Ports
//   mainClk, asyncReset        : clock, async active-high reset
//   req0/req1 -> gnt0/gnt1     : bus request / registered grant
//   ss*/sclk*/mosi*, miso*     : requester-side SPI
//   spi_ss/sclk/mosi, spi_miso : pad-side SPI
//   timeout_irq                : one-cycle pulse on a forced revoke
module spi_share_arbiter #(
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic mainClk,
  input  logic asyncReset,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1,
  input  logic ss0,
  input  logic sclk0,
  input  logic mosi0,
  input  logic ss1,
  input  logic sclk1,
  input  logic mosi1,
  output logic miso0,
  output logic miso1,
  output logic spi_ss,
  output logic spi_sclk,
  output logic spi_mosi,
  input  logic spi_miso,
  output logic timeout_irq
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, GAP} state_t;

  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] gap_cnt_q, gap_cnt_d;
  // 1 = requester 1 was served last. Resetting to 1 makes requester 0
  // win the first tie.
  logic       last_q, last_d;
  logic       revoke;       // forced release this cycle
  logic       blk0, blk1;   // requester locked out after a revoke

`ifdef SPI_ARB_TIMEOUT_EN
  localparam logic [15:0] HOLD_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] hold_q, hold_d;
  logic        blk0_q, blk0_d, blk1_q, blk1_d;
  logic        irq_q, irq_d;
  logic        owning;

  // hold_q reads 0 on the first OWN cycle because it is 0 outside OWN.
  always_comb begin
    owning = (state_q == OWN0) || (state_q == OWN1);
    revoke = owning && (hold_q == HOLD_LAST);
    hold_d = owning ? hold_q + 16'd1 : 16'd0;
    // The lock sets on revoke and clears once req is sampled low.
    blk0_d = (revoke && state_q == OWN0) || (blk0_q && req0);
    blk1_d = (revoke && state_q == OWN1) || (blk1_q && req1);
    irq_d  = revoke;
  end

  always_ff @(posedge mainClk or posedge asyncReset) begin
    if (asyncReset) begin
      hold_q <= '0;
      blk0_q <= 1'b0;
      blk1_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      blk0_q <= blk0_d;
      blk1_q <= blk1_d;
      irq_q  <= irq_d;
    end
  end

  assign blk0        = blk0_q;
  assign blk1        = blk1_q;
  assign timeout_irq = irq_q;
`else
  logic unused_cfg;
  assign unused_cfg  = ^16'(TIMEOUT_CYCLES);
  assign revoke      = 1'b0;
  assign blk0        = 1'b0;
  assign blk1        = 1'b0;
  assign timeout_irq = 1'b0;
`endif

  // State register
  always_ff @(posedge mainClk or posedge asyncReset) begin
    if (asyncReset) begin
      state_q   <= IDLE;
      gap_cnt_q <= '0;
      last_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      last_q    <= last_d;
    end
  end

  // Next state
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    last_d    = last_q;
    unique case (state_q)
      IDLE: begin
        if ((req0 && !blk0) && (req1 && !blk1)) begin
          state_d = last_q ? OWN0 : OWN1;
          last_d  = ~last_q;
        end else if (req0 && !blk0) begin
          state_d = OWN0;
          last_d  = 1'b0;
        end else if (req1 && !blk1) begin
          state_d = OWN1;
          last_d  = 1'b1;
        end
      end
      OWN0: if (revoke || (!req0 && ss0)) begin
        state_d   = GAP;
        gap_cnt_d = '0;
      end
      OWN1: if (revoke || (!req1 && ss1)) begin
        state_d   = GAP;
        gap_cnt_d = '0;
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = IDLE;
        else                       gap_cnt_d = gap_cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: the pads idle (ss=1, sclk=0, mosi=0) unless someone owns the bus.
  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    miso0    = 1'b0;
    miso1    = 1'b0;
    spi_ss   = 1'b1;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    unique case (state_q)
      OWN0: begin
        gnt0     = 1'b1;
        miso0    = spi_miso;
        spi_ss   = ss0;
        spi_sclk = sclk0;
        spi_mosi = mosi0;
      end
      OWN1: begin
        gnt1     = 1'b1;
        miso1    = spi_miso;
        spi_ss   = ss1;
        spi_sclk = sclk1;
        spi_mosi = mosi1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_share_arbiter.sv
// Directed bench for spi_share_arbiter (GAP_CYCLES=4, TIMEOUT_CYCLES=16).
module tb_spi_share_arbiter;

  logic clk = 1'b0, rst;
  logic req0, req1, gnt0, gnt1;
  logic ss0, sclk0, mosi0, ss1, sclk1, mosi1, miso0, miso1;
  logic spi_ss, spi_sclk, spi_mosi, miso, irq;
  int   n_chk = 0, n_err = 0, irq_cnt = 0;

  spi_share_arbiter #(.GAP_CYCLES(4), .TIMEOUT_CYCLES(16)) dut (
    .mainClk(clk), .asyncReset(rst),
    .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
    .ss0(ss0), .sclk0(sclk0), .mosi0(mosi0),
    .ss1(ss1), .sclk1(sclk1), .mosi1(mosi1),
    .miso0(miso0), .miso1(miso1),
    .spi_ss(spi_ss), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_miso(miso), .timeout_irq(irq)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (irq === 1'b1) irq_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic rst_pulse();
    rst = 1'b1; #1; rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req0 = 0; req1 = 0;
    ss0 = 1; sclk0 = 0; mosi0 = 0; ss1 = 1; sclk1 = 0; mosi1 = 0; miso = 1;
    #2;
    chk("rst_gnt", {gnt1, gnt0}, 2'b00);
    chk("rst_pad", {spi_ss, spi_sclk, spi_mosi}, 3'b100);
    chk("rst_miso", {miso1, miso0}, 2'b00);
    chk("rst_irq", irq, 1'b0);
    rst = 1'b0;
    step();

    // Single request, pass-through, MISO routing
    req0 = 1; #1;
    chk("lat0", gnt0, 1'b0);
    step();
    chk("gnt0", {gnt1, gnt0}, 2'b01);
    ss0 = 0; sclk0 = 1; mosi0 = 1; miso = 1; #1;
    chk("pass0", {spi_ss, spi_sclk, spi_mosi}, 3'b011);
    chk("miso0", {miso1, miso0}, 2'b01);
    sclk0 = 0; #1;
    chk("sclk0_lo", spi_sclk, 1'b0);

    // Release held off while ss0 low, then GAP with req1 pending
    req0 = 0; step();
    chk("hold_a", gnt0, 1'b1);
    step();
    chk("hold_b", gnt0, 1'b1);
    ss0 = 1; mosi0 = 0; req1 = 1; step();
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin ss0 = 0; sclk0 = 1; mosi0 = 1; end
      #1;
      chk($sformatf("gap_pad%0d", i), {spi_ss, spi_sclk, spi_mosi}, 3'b100);
      chk($sformatf("gap_gnt%0d", i), {gnt1, gnt0}, 2'b00);
      ss0 = 1; sclk0 = 0; mosi0 = 0;
      step();
    end
    chk("idle_gnt", {gnt1, gnt0}, 2'b00);
    step();
    chk("gnt1_after_gap", {gnt1, gnt0}, 2'b10);
    mosi1 = 1; #1;
    chk("pass1", {spi_mosi, miso1, miso0}, 3'b110);
    mosi1 = 0;

    // Async reset mid-transfer of owner 1
    ss1 = 0; #1;
    chk("own1_ss", spi_ss, 1'b0);
    rst = 1'b1; #1;
    chk("arst_pad", {spi_ss, gnt1, miso1}, 3'b100);
    rst = 1'b0; ss1 = 1;
    step();
    chk("gnt1_post_rst", {gnt1, gnt0}, 2'b10);

    // Tie right after reset -> requester 0, then 1 after the gap
    rst_pulse(); req0 = 1; step();
    chk("tie_rst", {gnt1, gnt0}, 2'b01);
    req0 = 0; step();
    repeat (4) step();
    chk("tie_idle", {gnt1, gnt0}, 2'b00);
    step();
    chk("tie_gnt1", {gnt1, gnt0}, 2'b10);

    // Tie with 1 served last -> requester 0
    req1 = 0; step();
    req0 = 1; req1 = 1;
    repeat (5) step();
    chk("tie_last", {gnt1, gnt0}, 2'b01);

    // Owner 0 holds with ss0 low and req1 pending
    rst_pulse(); ss0 = 0; step();
    chk("to_gnt0", {gnt1, gnt0}, 2'b01);
`ifdef SPI_ARB_TIMEOUT_EN
    repeat (15) step();
    chk("to_hold", {irq, gnt0}, 2'b01);
    step();
    chk("to_revoke", {irq, spi_ss, gnt1, gnt0}, 4'b1100);
    step();
    chk("to_irq_end", irq, 1'b0);
    repeat (3) step();
    chk("to_idle", {gnt1, gnt0}, 2'b00);
    step();
    chk("to_gnt1", {gnt1, gnt0}, 2'b10);
    req1 = 0; step();
    repeat (5) step();
    chk("to_blocked", gnt0, 1'b0);
    req0 = 0; step();
    req0 = 1; step();
    chk("to_regrant", gnt0, 1'b1);
    chk("to_irq_cnt", irq_cnt, 1);
`else
    repeat (24) step();
    chk("nto_hold", {gnt1, gnt0}, 2'b01);
    chk("nto_irq", irq_cnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
